user_obi_pixel_sink: RTL and testbench

USER_OBI_PIXEL_SINK -- requirements
Module: user_obi_pixel_sink

---
 rtl/obi_pkg.sv | 29 ++
 rtl/user_obi_pixel_sink_pkg.sv | 21 ++
 rtl/user_obi_pixel_sink_if.sv | 11 +
 rtl/user_pixel_fifo.sv | 64 ++++++
 rtl/user_obi_pixel_sink.sv | 146 ++++++++++++++
 tb/tb_user_obi_pixel_sink.sv | 245 ++++++++++++++++++++++++
 6 files changed

// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - OBI port configuration and request/response struct types
package obi_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
    } obi_rsp_t;

endpackage

// File: rtl/user_obi_pixel_sink_pkg.sv
// rtl/user_obi_pixel_sink_pkg.sv - register map and STATUS bit layout of the pixel sink
package user_obi_pixel_sink_pkg;

    // Register index taken from addr[3:2]
    typedef enum logic [1:0] {
        RegData   = 2'd0,
        RegStatus = 2'd1,
        RegCtrl   = 2'd2,
        RegResult = 2'd3
    } reg_idx_e;

    localparam int unsigned StatusEmptyBit = 0;
    localparam int unsigned StatusFullBit  = 1;
    localparam int unsigned StatusCountLsb = 2;

    // The sticky bit sits directly above the count field, whose width depends on the FIFO depth
    function automatic int unsigned status_sticky_bit(input int unsigned count_width);
        return StatusCountLsb + count_width;
    endfunction

endpackage

// File: rtl/user_obi_pixel_sink_if.sv
// rtl/user_obi_pixel_sink_if.sv - OBI request/response bundle with manager and subordinate views
// Ports: req (manager -> sink), rsp (sink -> manager)
interface user_obi_pixel_sink_if;

    obi_pkg::obi_req_t req;
    obi_pkg::obi_rsp_t rsp;

    modport master (output req, input  rsp);
    modport slave  (input  req, output rsp);

endinterface

// File: rtl/user_pixel_fifo.sv
// rtl/user_pixel_fifo.sv - synchronous pixel word FIFO with push/pop/flush and occupancy count
// Ports: clk_i, rst_ni (async active-low), i_push/i_data, i_pop, i_flush,
//        o_data (head word), o_full, o_empty, o_count (0..Depth)
module user_pixel_fifo #(
    parameter  int unsigned Depth = 4,
    parameter  int unsigned Width = 32,
    localparam int unsigned PW    = $clog2(Depth),
    localparam int unsigned CW    = PW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  logic [Width-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [Width-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [Width-1:0] r_mem [Depth];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CW'(Depth));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk_i) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are PW bits wide so they wrap modulo Depth (Depth is a power of two)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            // Flush dominates any same-cycle pop or push
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/user_obi_pixel_sink.sv
// rtl/user_obi_pixel_sink.sv - OBI subordinate that queues pixel words for compute and holds its result
// Ports: clk_i, rst_ni (async active-low), obi_req_i/obi_rsp_o (OBI bus),
//        pixels_o/pixels_valid_o/pixels_ready_i (FIFO head to compute),
//        result_i/result_valid_i (result capture from compute)
module user_obi_pixel_sink
    import user_obi_pixel_sink_pkg::*;
#(
    parameter obi_pkg::obi_cfg_t ObiCfg    = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
    parameter int unsigned       FifoDepth = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  obi_req_t                    obi_req_i,
    output obi_rsp_t                    obi_rsp_o,
    output logic [ObiCfg.DataWidth-1:0] pixels_o,
    output logic                        pixels_valid_o,
    input  logic                        pixels_ready_i,
    input  logic [ObiCfg.DataWidth-1:0] result_i,
    input  logic                        result_valid_i
);

    localparam int unsigned DW        = ObiCfg.DataWidth;
    localparam int unsigned IW        = ObiCfg.IdWidth;
    localparam int unsigned CW        = $clog2(FifoDepth) + 1;
    localparam int unsigned StickyBit = status_sticky_bit(CW);

    reg_idx_e        w_idx;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic            w_gnt;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic            w_rd_result;
    logic [DW-1:0]   w_status;
    logic [DW-1:0]   w_rdata;
    logic            w_err;
    logic            w_unused_addr;

    logic            r_rvalid;
    logic [DW-1:0]   r_rdata;
    logic            r_err;
    logic [IW-1:0]   r_rid;
    logic [DW-1:0]   r_result;
    logic            r_sticky;

    assign w_idx         = reg_idx_e'(obi_req_i.addr[3:2]);
    assign w_unused_addr = ^{obi_req_i.addr[ObiCfg.AddrWidth-1:4], obi_req_i.addr[1:0]};

    // Only a DATA write against a full FIFO waits; a same-cycle pop does not release it
    assign w_gnt = obi_req_i.req && !(obi_req_i.we && (w_idx == RegData) && w_full);

    assign w_push      = w_gnt && obi_req_i.we && (w_idx == RegData) && (&obi_req_i.be);
    assign w_flush     = w_gnt && obi_req_i.we && (w_idx == RegCtrl) && obi_req_i.wdata[0];
    assign w_rd_result = w_gnt && !obi_req_i.we && (w_idx == RegResult);
    assign w_pop       = pixels_valid_o && pixels_ready_i;

    assign pixels_valid_o = !w_empty;

    user_pixel_fifo #(
        .Depth (FifoDepth),
        .Width (DW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_data  (obi_req_i.wdata),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (pixels_o),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_status                        = '0;
        w_status[StatusEmptyBit]        = w_empty;
        w_status[StatusFullBit]         = w_full;
        w_status[StatusCountLsb +: CW]  = w_count;
        w_status[StickyBit]             = r_sticky;
    end

    // Response payload is decided at the grant and registered for the next cycle
    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        if (w_gnt) begin
            if (obi_req_i.we) begin
                unique case (w_idx)
                    RegData:   w_err = !(&obi_req_i.be);
                    RegStatus: w_err = 1'b1;
                    RegCtrl:   w_err = 1'b0;
                    RegResult: w_err = 1'b1;
                endcase
            end else begin
                unique case (w_idx)
                    RegData:   w_rdata = '0;
                    RegStatus: w_rdata = w_status;
                    RegCtrl:   w_rdata = '0;
                    RegResult: w_rdata = r_result;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_rid    <= '0;
        end else begin
            r_rvalid <= w_gnt;
            r_rdata  <= w_rdata;
            r_err    <= w_err;
            r_rid    <= w_gnt ? obi_req_i.aid : '0;
        end
    end

    // A capture wins over the read-clear so a result arriving during a RESULT read is not lost
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_result <= '0;
            r_sticky <= 1'b0;
        end else if (result_valid_i) begin
            r_result <= result_i;
            r_sticky <= 1'b1;
        end else if (w_rd_result) begin
            r_sticky <= 1'b0;
        end
    end

    always_comb begin
        obi_rsp_o        = '0;
        obi_rsp_o.gnt    = w_gnt;
        obi_rsp_o.rvalid = r_rvalid;
        obi_rsp_o.rdata  = r_rdata;
        obi_rsp_o.rid    = r_rid;
        obi_rsp_o.err    = r_err;
    end

endmodule

// File: tb/tb_user_obi_pixel_sink.sv
// tb/tb_user_obi_pixel_sink.sv - scoreboard bench for the OBI pixel sink
module tb_user_obi_pixel_sink;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pixels;
    logic        pixels_valid;
    logic        pixels_ready;
    logic [31:0] result;
    logic        result_valid;

    always #5 clk = ~clk;

    user_obi_pixel_sink_if bus ();

    user_obi_pixel_sink #(.FifoDepth(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .obi_req_i      (bus.req),
        .obi_rsp_o      (bus.rsp),
        .pixels_o       (pixels),
        .pixels_valid_o (pixels_valid),
        .pixels_ready_i (pixels_ready),
        .result_i       (result),
        .result_valid_i (result_valid)
    );

    typedef struct {
        logic [3:0]  rid;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_CTRL = 32'h8, A_RES = 32'hC;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid consumes one scoreboard entry; idle cycles must carry zero payload
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp.rvalid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rvalid: got rid %h with empty scoreboard", bus.rsp.rid);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_rid", 32'(bus.rsp.rid), 32'(mon_e.rid));
                    check("rsp_rdata", bus.rsp.rdata, mon_e.rdata);
                    check("rsp_err", 32'(bus.rsp.err), 32'(mon_e.err));
                end
            end else begin
                check("idle_rdata", bus.rsp.rdata, 32'h0);
                check("idle_err", 32'(bus.rsp.err), 32'h0);
            end
        end
    end

    task automatic xfer(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wdata, input logic [3:0] aid,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int   cyc;
        exp_t e;
        @(negedge clk);
        bus.req.req   = 1'b1;
        bus.req.addr  = addr;
        bus.req.we    = we;
        bus.req.be    = be;
        bus.req.wdata = wdata;
        bus.req.aid   = aid;
        #1;
        cyc = 0;
        while (!bus.rsp.gnt && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (!bus.rsp.gnt) begin
            n_tests++;
            n_fail++;
            $display("FAIL gnt_timeout: got gnt 0 for addr %h, required 1 within 40 cycles", addr);
            bus.req.req = 1'b0;
        end else begin
            e.rid   = aid;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            bus.req.req = 1'b0;
        end
    endtask

    task automatic pop_one(input logic [31:0] exp_head);
        @(negedge clk);
        check("pop_valid", 32'(pixels_valid), 32'h1);
        check("pop_head", pixels, exp_head);
        pixels_ready = 1'b1;
        @(posedge clk);
        #1;
        pixels_ready = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.req      = '0;
        pixels_ready = 1'b0;
        result       = '0;
        result_valid = 1'b0;
        #1;
        check("rst_gnt_idle", 32'(bus.rsp.gnt), 32'h0);
        bus.req.req = 1'b1;
        bus.req.we  = 1'b1;
        bus.req.be  = 4'hF;
        #1;
        check("rst_gnt_follows_req", 32'(bus.rsp.gnt), 32'h1);
        check("rst_pixels_valid", 32'(pixels_valid), 32'h0);
        check("rst_rvalid", 32'(bus.rsp.rvalid), 32'h0);
        check("rst_rdata", bus.rsp.rdata, 32'h0);
        check("rst_rid", 32'(bus.rsp.rid), 32'h0);
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single word through to compute
        xfer(A_DATA, 1'b1, 4'hF, 32'h04030201, 4'd1, 32'h0, 1'b0);
        check("t1_valid", 32'(pixels_valid), 32'h1);
        check("t1_head", pixels, 32'h04030201);
        xfer(A_STAT, 1'b0, 4'hF, 32'h0, 4'd2, 32'h04, 1'b0);
        xfer(A_DATA, 1'b0, 4'hF, 32'h0, 4'd3, 32'h0, 1'b0);
        xfer(A_CTRL, 1'b0, 4'hF, 32'h0, 4'd4, 32'h0, 1'b0);
        pop_one(32'h04030201);
        check("t1_empty_after_pop", 32'(pixels_valid), 32'h0);
        xfer(A_STAT, 1'b0, 4'hF, 32'h0, 4'd5, 32'h01, 1'b0);

        // Fill to full, stall the fifth write until one pop
        for (int i = 1; i <= 4; i++)
            xfer(A_DATA, 1'b1, 4'hF, 32'h11 * i, 4'(i + 2), 32'h0, 1'b0);
        xfer(A_STAT, 1'b0, 4'hF, 32'h0, 4'd7, 32'h12, 1'b0);
        fork
            xfer(A_DATA, 1'b1, 4'hF, 32'h55, 4'd8, 32'h0, 1'b0);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    #2;
                    check("t2_stall_gnt", 32'(bus.rsp.gnt), 32'h0);
                end
                pixels_ready = 1'b1;
                #1;
                check("t2_stall_with_pop", 32'(bus.rsp.gnt), 32'h0);
                @(posedge clk);
                #1;
                pixels_ready = 1'b0;
            end
        join
        xfer(A_STAT, 1'b0, 4'hF, 32'h0, 4'd9, 32'h12, 1'b0);
        pop_one(32'h22);
        pop_one(32'h33);
        pop_one(32'h44);
        pop_one(32'h55);
        xfer(A_STAT, 1'b0, 4'hF, 32'h0, 4'd10, 32'h01, 1'b0);

        // Flush via CTRL (upper address bits ignored)
        for (int i = 1; i <= 3; i++)
            xfer(A_DATA, 1'b1, 4'hF, 32'hA0 + i, 4'(i), 32'h0, 1'b0);
        check("t3_valid_before_flush", 32'(pixels_valid), 32'h1);
        xfer(32'h1000 | A_CTRL, 1'b1, 4'hF, 32'h1, 4'd11, 32'h0, 1'b0);
        check("t3_valid_after_flush", 32'(pixels_valid), 32'h0);
        xfer(A_STAT, 1'b0, 4'hF, 32'h0, 4'd12, 32'h01, 1'b0);

        // Result capture and sticky bit
        @(negedge clk);
        result       = 32'hDEADBEEF;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        xfer(A_STAT, 1'b0, 4'hF, 32'h0, 4'd13, 32'h21, 1'b0);
        xfer(A_RES, 1'b0, 4'hF, 32'h0, 4'd14, 32'hDEADBEEF, 1'b0);
        xfer(A_STAT, 1'b0, 4'hF, 32'h0, 4'd15, 32'h01, 1'b0);
        fork
            xfer(A_RES, 1'b0, 4'hF, 32'h0, 4'd3, 32'hDEADBEEF, 1'b0);
            begin
                @(negedge clk);
                result       = 32'hCAFEF00D;
                result_valid = 1'b1;
                @(negedge clk);
                result_valid = 1'b0;
            end
        join
        xfer(A_STAT, 1'b0, 4'hF, 32'h0, 4'd4, 32'h21, 1'b0);
        xfer(A_RES, 1'b0, 4'hF, 32'h0, 4'd5, 32'hCAFEF00D, 1'b0);
        xfer(A_STAT, 1'b0, 4'hF, 32'h0, 4'd6, 32'h01, 1'b0);

        // Error responses leave the FIFO alone
        xfer(A_DATA, 1'b1, 4'hF, 32'h99, 4'd1, 32'h0, 1'b0);
        xfer(A_DATA, 1'b1, 4'h3, 32'hBAD, 4'd7, 32'h0, 1'b1);
        xfer(A_STAT, 1'b1, 4'hF, 32'hFFFF, 4'd9, 32'h0, 1'b1);
        xfer(A_RES, 1'b1, 4'hF, 32'hFFFF, 4'd10, 32'h0, 1'b1);
        xfer(A_CTRL, 1'b1, 4'hF, 32'h0, 4'd12, 32'h0, 1'b0);
        xfer(A_STAT, 1'b0, 4'hF, 32'h0, 4'd11, 32'h04, 1'b0);
        pop_one(32'h99);

        // Reset right after a grant drops the response
        @(negedge clk);
        bus.req.req   = 1'b1;
        bus.req.addr  = A_DATA;
        bus.req.we    = 1'b1;
        bus.req.be    = 4'hF;
        bus.req.wdata = 32'h77;
        bus.req.aid   = 4'd5;
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        bus.req.req = 1'b0;
        #1;
        check("t6_rvalid", 32'(bus.rsp.rvalid), 32'h0);
        check("t6_rdata", bus.rsp.rdata, 32'h0);
        check("t6_rid", 32'(bus.rsp.rid), 32'h0);
        check("t6_pixels_valid", 32'(pixels_valid), 32'h0);
        @(negedge clk);
        check("t6_rvalid_held", 32'(bus.rsp.rvalid), 32'h0);
        rst_n = 1'b1;
        xfer(A_STAT, 1'b0, 4'hF, 32'h0, 4'd2, 32'h01, 1'b0);
        xfer(A_RES, 1'b0, 4'hF, 32'h0, 4'd3, 32'h0, 1'b0);
        xfer(A_DATA, 1'b1, 4'hF, 32'h88, 4'd6, 32'h0, 1'b0);
        pop_one(32'h88);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
